// File: rtl/uart_tx_fifo_if.sv
// Host-side and transmitter-side signals of the UART transmit FIFO.
// The slave modport is the FIFO's own view of these signals.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              i_clk_en;
    logic              i_tx_en;
    logic              i_tx_empty;
    logic [7:0]        i_wr_data;
    logic              i_wr_en;
    logic              i_flush;
    logic              i_clr_ovf;
    logic [7:0]        o_tx_data;
    logic              o_ld_tx_data;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_overflow;

    modport slave (
        input  i_clk_en,
        input  i_tx_en,
        input  i_tx_empty,
        input  i_wr_data,
        input  i_wr_en,
        input  i_flush,
        input  i_clr_ovf,
        output o_tx_data,
        output o_ld_tx_data,
        output o_count,
        output o_full,
        output o_overflow
    );

    modport master (
        output i_clk_en,
        output i_tx_en,
        output i_tx_empty,
        output i_wr_data,
        output i_wr_en,
        output i_flush,
        output i_clr_ovf,
        input  o_tx_data,
        input  o_ld_tx_data,
        input  o_count,
        input  o_full,
        input  o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter through a registered show-ahead head stage.
// Capacity is DEPTH array entries plus the output register.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic           i_sys_clk,
    input logic           i_rst,
    uart_tx_fifo_if.slave bus
);
    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_CAP = CNT_W'(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  arr_cnt;
    logic [CNT_W-1:0]  arr_cnt_next;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next;
    logic [7:0]        tx_data_r;
    logic              valid_r;
    logic              valid_next;
    logic              overflow_r;

    logic full;
    logic pop;
    logic wr_ok;
    logic load_slot;
    logic from_arr;
    logic bypass;
    logic arr_wr;
    logic ovf_set;

    // A pop is the cycle in which the transmitter latches the head byte.
    always_comb begin
        full         = (count_r == CNT_CAP);
        pop          = bus.i_clk_en & bus.i_tx_en & bus.i_tx_empty & valid_r;
        wr_ok        = bus.i_wr_en & (~full | pop);
        load_slot    = ~valid_r | pop;
        from_arr     = load_slot & (arr_cnt != '0);
        bypass       = load_slot & (arr_cnt == '0) & wr_ok;
        arr_wr       = wr_ok & ~bypass;
        ovf_set      = bus.i_wr_en & full & ~pop & ~bus.i_flush;

        arr_cnt_next = arr_cnt;
        if (arr_wr && !from_arr) begin
            arr_cnt_next = arr_cnt + CNT_ONE;
        end else if (!arr_wr && from_arr) begin
            arr_cnt_next = arr_cnt - CNT_ONE;
        end

        valid_next   = load_slot ? (from_arr | bypass) : valid_r;
        count_next   = arr_cnt_next + {{ADDR_W{1'b0}}, valid_next};
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            arr_cnt    <= '0;
            count_r    <= '0;
            tx_data_r  <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_r <= 1'b1;
            end else if (bus.i_clr_ovf) begin
                overflow_r <= 1'b0;
            end

            // Flush wins over any same-cycle write or pop; tx_data keeps its last value.
            if (bus.i_flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                arr_cnt <= '0;
                count_r <= '0;
                valid_r <= 1'b0;
            end else begin
                if (from_arr) begin
                    tx_data_r <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + PTR_ONE;
                end else if (bypass) begin
                    tx_data_r <= bus.i_wr_data;
                end
                if (arr_wr) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                arr_cnt <= arr_cnt_next;
                valid_r <= valid_next;
                count_r <= count_next;
            end
        end
    end

    // Storage is not reset; the head read above sees the old entry when rd_ptr == wr_ptr.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst && !bus.i_flush && arr_wr) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    assign bus.o_tx_data    = tx_data_r;
    assign bus.o_ld_tx_data = valid_r;
    assign bus.o_count      = count_r;
    assign bus.o_full       = full;
    assign bus.o_overflow   = overflow_r;

endmodule
